mips_mc_control: RTL and testbench

- Multi-cycle MIPS main control unit: Moore FSM that sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives the ALU operand selects (ALUsrcA, ALUsrcB) and the 4-bit alu_operation code, plus all datapath enables.
- Consumes opcode/funct from the instruction register and zero_flag/overflow back from the ALU.

---
 rtl/mips_ctrl_pkg.sv | 48 ++++
 rtl/mips_alu_op_dec.sv | 26 ++
 rtl/mips_mc_control.sv | 160 ++++++++++++++++
 tb/tb_mips_mc_control.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: states, opcode/funct
// values, ALU operation codes and datapath mux selects.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        INIT    = 4'd0,
        FETCH   = 4'd1,
        DECODE  = 4'd2,
        MEMADR  = 4'd3,
        MEMRD   = 4'd4,
        MEMWB   = 4'd5,
        MEMWR   = 4'd6,
        EXECUTE = 4'd7,
        ALUWB   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        BRANCH  = 4'd11,
        JUMP    = 4'd12,
        ILLEGAL = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_MUL = 6'b011000;
    localparam logic [5:0] FN_NOT = 6'b100111;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_MUL = 4'b0000;
    localparam logic [3:0] ALU_NOT = 4'b0011;

    localparam logic [1:0] SRCB_REGB   = 2'b00;
    localparam logic [1:0] SRCB_ONE    = 2'b01;
    localparam logic [1:0] SRCB_EXT    = 2'b10;
    localparam logic [1:0] SRCB_EXT_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_alu_op_dec.sv
// R-type funct decoder: maps funct to the ALU operation code and flags
// whether the funct is one the datapath supports.
module mips_alu_op_dec
    import mips_ctrl_pkg::*;
#(
    parameter int OPW  = 6,
    parameter int AOPW = 4
) (
    input  logic [OPW-1:0]  funct,
    output logic [AOPW-1:0] alu_operation,
    output logic            funct_valid
);

    always_comb begin
        alu_operation = ALU_ADD;
        funct_valid   = 1'b1;
        case (funct)
            FN_ADD:  alu_operation = ALU_ADD;
            FN_SUB:  alu_operation = ALU_SUB;
            FN_MUL:  alu_operation = ALU_MUL;
            FN_NOT:  alu_operation = ALU_NOT;
            default: funct_valid   = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_mc_control.sv
// Multi-cycle MIPS main control: Moore FSM sequencing fetch, decode, execute,
// memory and writeback, with overflow-suppressed arithmetic writeback.
module mips_mc_control
    import mips_ctrl_pkg::*;
#(
    parameter int OPW  = 6,
    parameter int AOPW = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [OPW-1:0]  opcode,
    input  logic [OPW-1:0]  funct,
    input  logic            zero_flag,
    input  logic            overflow,
    output logic            ALUsrcA,
    output logic [1:0]      ALUsrcB,
    output logic [AOPW-1:0] alu_operation,
    output logic            pc_en,
    output logic [1:0]      pc_source,
    output logic            IorD,
    output logic            mem_read,
    output logic            mem_write,
    output logic            IR_write,
    output logic            reg_write,
    output logic            reg_dst,
    output logic            mem_to_reg,
    output logic            ovf_exc,
    output logic            illegal_op,
    output logic [3:0]      state_dbg
);

    state_t          state, state_next;
    logic            ovf_latch, ovf_next;
    logic            pc_write, pc_write_cond;
    logic [AOPW-1:0] dec_op;
    logic            funct_valid;

    mips_alu_op_dec #(.OPW(OPW), .AOPW(AOPW)) u_alu_op_dec (
        .funct         (funct),
        .alu_operation (dec_op),
        .funct_valid   (funct_valid)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= INIT;
            ovf_latch <= 1'b0;
        end else begin
            state     <= state_next;
            ovf_latch <= ovf_next;
        end
    end

    always_comb begin
        state_next    = FETCH;
        ovf_next      = ovf_latch;
        ALUsrcA       = 1'b0;
        ALUsrcB       = SRCB_REGB;
        alu_operation = '0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = PCSRC_ALU;
        IorD          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        IR_write      = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        ovf_exc       = 1'b0;
        illegal_op    = 1'b0;
        case (state)
            INIT: state_next = FETCH;
            FETCH: begin
                mem_read      = 1'b1;
                IR_write      = 1'b1;
                ALUsrcB       = SRCB_ONE;
                alu_operation = ALU_ADD;
                pc_write      = 1'b1;
                state_next    = DECODE;
            end
            DECODE: begin
                ALUsrcB       = SRCB_EXT;
                alu_operation = ALU_ADD;
                case (opcode)
                    OP_LW, OP_SW: state_next = MEMADR;
                    OP_RTYPE:     state_next = funct_valid ? EXECUTE : ILLEGAL;
                    OP_BEQ:       state_next = BRANCH;
                    OP_J:         state_next = JUMP;
                    OP_ADDI:      state_next = ADDIEX;
                    default:      state_next = ILLEGAL;
                endcase
            end
            MEMADR: begin
                ALUsrcA       = 1'b1;
                ALUsrcB       = SRCB_EXT;
                alu_operation = ALU_ADD;
                state_next    = (opcode == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                IorD       = 1'b1;
                mem_read   = 1'b1;
                state_next = MEMWB;
            end
            // Address select stays on ALU_out; no memory strobe is active here.
            MEMWB: begin
                IorD       = 1'b1;
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_next = FETCH;
            end
            MEMWR: begin
                IorD       = 1'b1;
                mem_write  = 1'b1;
                state_next = FETCH;
            end
            EXECUTE: begin
                ALUsrcA       = 1'b1;
                alu_operation = dec_op;
                ovf_next      = overflow & ((dec_op == ALU_ADD) || (dec_op == ALU_SUB));
                state_next    = ALUWB;
            end
            ALUWB, ADDIWB: begin
                reg_dst    = (state == ALUWB);
                reg_write  = ~ovf_latch;
                ovf_exc    = ovf_latch;
                ovf_next   = 1'b0;
                state_next = FETCH;
            end
            ADDIEX: begin
                ALUsrcA       = 1'b1;
                ALUsrcB       = SRCB_EXT;
                alu_operation = ALU_ADD;
                ovf_next      = overflow;
                state_next    = ADDIWB;
            end
            BRANCH: begin
                ALUsrcA       = 1'b1;
                alu_operation = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
                state_next    = FETCH;
            end
            JUMP: begin
                pc_write   = 1'b1;
                pc_source  = PCSRC_JUMP;
                state_next = FETCH;
            end
            ILLEGAL: begin
                illegal_op = 1'b1;
                state_next = FETCH;
            end
            default: state_next = FETCH;
        endcase
    end

    assign pc_en     = pc_write | (pc_write_cond & zero_flag);
    assign state_dbg = state;

endmodule

// File: tb/tb_mips_mc_control.sv
// Scoreboard bench for mips_mc_control: random instruction stream, expected
// per-cycle control vectors queued by the stimulus, compared by a monitor.
module tb_mips_mc_control;

    typedef struct packed {
        logic       a;
        logic [1:0] b;
        logic [3:0] op;
        logic       pc_en;
        logic [1:0] pcs;
        logic       iord;
        logic       mr;
        logic       mw;
        logic       irw;
        logic       rw;
        logic       rd;
        logic       m2r;
        logic       ovf;
        logic       ill;
    } vec_t;

    localparam int K_LW = 0, K_SW = 1, K_RADD = 2, K_RSUB = 3, K_RMUL = 4, K_RNOT = 5;
    localparam int K_RBAD = 6, K_ADDI = 7, K_BEQ = 8, K_J = 9, K_ILL = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode, funct;
    logic       zero_flag, overflow;
    logic       ALUsrcA;
    logic [1:0] ALUsrcB;
    logic [3:0] alu_operation;
    logic       pc_en;
    logic [1:0] pc_source;
    logic       IorD, mem_read, mem_write, IR_write, reg_write, reg_dst, mem_to_reg;
    logic       ovf_exc, illegal_op;
    logic [3:0] state_dbg;

    int   n_vec = 0;
    int   n_bad = 0;
    vec_t exp_q[$];

    mips_mc_control #(.OPW(6), .AOPW(4)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
        .zero_flag(zero_flag), .overflow(overflow),
        .ALUsrcA(ALUsrcA), .ALUsrcB(ALUsrcB), .alu_operation(alu_operation),
        .pc_en(pc_en), .pc_source(pc_source), .IorD(IorD),
        .mem_read(mem_read), .mem_write(mem_write), .IR_write(IR_write),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .ovf_exc(ovf_exc), .illegal_op(illegal_op), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    function automatic vec_t observed();
        vec_t v;
        v = '{ALUsrcA, ALUsrcB, alu_operation, pc_en, pc_source, IorD, mem_read,
              mem_write, IR_write, reg_write, reg_dst, mem_to_reg, ovf_exc, illegal_op};
        return v;
    endfunction

    // Expected control outputs for cycle i (0 = fetch) of an instruction class.
    function automatic vec_t model(input int kind, input int i, input bit ovf_ex, input bit zf);
        vec_t v;
        v = '0;
        if (i == 0) begin
            v.b = 2'b01; v.op = 4'b0010; v.pc_en = 1'b1; v.mr = 1'b1; v.irw = 1'b1;
        end else if (i == 1) begin
            v.b = 2'b10; v.op = 4'b0010;
        end else begin
            case (kind)
                K_LW, K_SW: begin
                    if (i == 2) begin v.a = 1'b1; v.b = 2'b10; v.op = 4'b0010; end
                    else if (kind == K_SW) begin v.iord = 1'b1; v.mw = 1'b1; end
                    else if (i == 3) begin v.iord = 1'b1; v.mr = 1'b1; end
                    else begin v.iord = 1'b1; v.rw = 1'b1; v.m2r = 1'b1; end
                end
                K_RADD, K_RSUB, K_RMUL, K_RNOT: begin
                    if (i == 2) begin
                        v.a = 1'b1;
                        v.op = (kind == K_RADD) ? 4'b0010 : (kind == K_RSUB) ? 4'b0110 :
                               (kind == K_RMUL) ? 4'b0000 : 4'b0011;
                    end else begin
                        v.rd = 1'b1;
                        v.ovf = ovf_ex && (kind == K_RADD || kind == K_RSUB);
                        v.rw = !v.ovf;
                    end
                end
                K_ADDI: begin
                    if (i == 2) begin v.a = 1'b1; v.b = 2'b10; v.op = 4'b0010; end
                    else begin v.ovf = ovf_ex; v.rw = !ovf_ex; end
                end
                K_BEQ: begin v.a = 1'b1; v.op = 4'b0110; v.pcs = 2'b01; v.pc_en = zf; end
                K_J:   begin v.pcs = 2'b10; v.pc_en = 1'b1; end
                default: v.ill = 1'b1;
            endcase
        end
        return v;
    endfunction

    function automatic int cycles_of(input int kind);
        case (kind)
            K_LW: return 5;
            K_SW, K_RADD, K_RSUB, K_RMUL, K_RNOT, K_ADDI: return 4;
            default: return 3;
        endcase
    endfunction

    function automatic bit legal_op(input logic [5:0] o);
        return o == 6'b000000 || o == 6'b100011 || o == 6'b101011 ||
               o == 6'b000100 || o == 6'b000010 || o == 6'b001000;
    endfunction

    function automatic bit legal_fn(input logic [5:0] f);
        return f == 6'b100000 || f == 6'b100010 || f == 6'b011000 || f == 6'b100111;
    endfunction

    task automatic check_bit(input string name, input logic got, input logic want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, got, want, $time);
        end
    endtask

    // Monitor: every cycle with an outstanding expectation is compared in full.
    initial begin
        vec_t e, g;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                g = observed();
                n_vec++;
                if (g !== e) begin
                    n_bad++;
                    $display("FAIL ctrl_vec: got %h expected %h (state_dbg %0d) at %0t",
                             g, e, state_dbg, $time);
                end
            end
        end
    end

    task automatic run_instr(input int kind, input int ovf_sel, input int zf_sel,
                             input bit rst_mid, input logic [5:0] force_code);
        logic [5:0] o, f;
        bit         ovf_ex;
        ovf_ex = 1'b0;
        f = 6'($urandom_range(0, 63));
        case (kind)
            K_LW:   o = 6'b100011;
            K_SW:   o = 6'b101011;
            K_RADD: begin o = 6'b000000; f = 6'b100000; end
            K_RSUB: begin o = 6'b000000; f = 6'b100010; end
            K_RMUL: begin o = 6'b000000; f = 6'b011000; end
            K_RNOT: begin o = 6'b000000; f = 6'b100111; end
            K_RBAD: begin
                o = 6'b000000;
                f = force_code;
                while (legal_fn(f)) f = 6'($urandom_range(0, 63));
            end
            K_ADDI: o = 6'b001000;
            K_BEQ:  o = 6'b000100;
            K_J:    o = 6'b000010;
            default: begin
                o = force_code;
                while (legal_op(o)) o = 6'($urandom_range(0, 63));
            end
        endcase
        for (int i = 0; i < cycles_of(kind); i++) begin
            @(posedge clk); #1;
            zero_flag = 1'($urandom);
            overflow  = 1'($urandom);
            if (i == 0) begin opcode = o; funct = f; end
            if (i == 2) begin
                if (ovf_sel < 2) overflow = 1'(ovf_sel);
                if (zf_sel < 2) zero_flag = 1'(zf_sel);
                ovf_ex = overflow;
            end
            if (rst_mid && i == 3) begin
                check_bit("mw_before_reset", mem_write, 1'b1);
                reset = 1'b0;
                #1;
                check_bit("mw_async_drop", mem_write, 1'b0);
                exp_q.push_back('0);
                for (int r = 0; r < 2; r++) begin
                    @(posedge clk); #1;
                    exp_q.push_back('0);
                end
                @(posedge clk); #1;
                reset = 1'b1;
                exp_q.push_back('0);
                return;
            end
            exp_q.push_back(model(kind, i, ovf_ex, zero_flag));
        end
    endtask

    initial begin
        reset = 1'b0; opcode = '0; funct = '0; zero_flag = 1'b0; overflow = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            exp_q.push_back('0);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        exp_q.push_back('0);

        run_instr(K_LW,   2, 2, 1'b0, 6'd0);
        run_instr(K_RADD, 1, 2, 1'b0, 6'd0);
        run_instr(K_RADD, 0, 2, 1'b0, 6'd0);
        run_instr(K_BEQ,  2, 1, 1'b0, 6'd0);
        run_instr(K_BEQ,  2, 0, 1'b0, 6'd0);
        run_instr(K_ILL,  2, 2, 1'b0, 6'b111111);
        run_instr(K_RBAD, 2, 2, 1'b0, 6'b000001);
        run_instr(K_ADDI, 1, 2, 1'b0, 6'd0);
        run_instr(K_RMUL, 1, 2, 1'b0, 6'd0);
        run_instr(K_SW,   2, 2, 1'b1, 6'd0);
        run_instr(K_J,    2, 2, 1'b0, 6'd0);

        for (int n = 0; n < 120; n++) begin
            int k;
            k = int'($urandom_range(0, 10));
            run_instr(k, 2, 2, (k == K_SW) && ($urandom_range(0, 7) == 0),
                      6'($urandom_range(0, 63)));
        end

        @(negedge clk);
        @(negedge clk);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
